// File: rtl/load_unit_if.sv
// rtl/load_unit_if.sv - request, memory-read and response signals of the load unit
interface load_unit_if #(
  parameter int XLEN = 32,
  parameter int AW   = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_funct3;
  logic [AW-1:0]   req_addr;

  logic            mem_req;
  logic [AW-1:0]   mem_addr;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;

  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_data;
  logic            resp_err;

  modport master (
    output req_valid, req_funct3, req_addr, mem_rvalid, mem_rdata, resp_ready,
    input  req_ready, mem_req, mem_addr, resp_valid, resp_data, resp_err
  );

  modport slave (
    input  req_valid, req_funct3, req_addr, mem_rvalid, mem_rdata, resp_ready,
    output req_ready, mem_req, mem_addr, resp_valid, resp_data, resp_err
  );
endinterface

// File: rtl/load_unit.sv
// rtl/load_unit.sv - RISC-V style load unit: one or two aligned memory beats, then extract/extend.
// LOAD_UNIT_MISALIGN_SPLIT_EN enables misaligned loads, including word-crossing two-beat loads.
module load_unit #(
  parameter int XLEN = 32,
  parameter int AW   = 32
) (
  input logic       clk,
  input logic       rst,
  load_unit_if.slave bus
);
  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

  state_t          state, state_nxt;
  logic [2:0]      f3_q;
  logic [AW-1:0]   addr_q;
  logic [XLEN-1:0] beat0_q;
  logic [XLEN-1:0] resp_data_q;
  logic            resp_err_q;

  // f3[1:0] encodes the access size for every legal code
  function automatic logic [3:0] size_of(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 4'd1;
      2'b01:   return 4'd2;
      2'b10:   return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

  function automatic logic legal_f3(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: return 1'b1;
      3'b011, 3'b110:                         return (XLEN == 64);
      default:                                return 1'b0;
    endcase
  endfunction

  logic            req_ok;
  logic [OW-1:0]   off_q;
  logic [3:0]      size_q;
  logic [AW-1:0]   base_addr;
  logic            split;
  logic [2*XLEN-1:0] word;
  logic [XLEN-1:0] sh;
  logic [XLEN-1:0] res;
  logic            ext;

  assign off_q     = addr_q[OW-1:0];
  assign size_q    = size_of(f3_q);
  assign base_addr = {addr_q[AW-1:OW], {OW{1'b0}}};

`ifdef LOAD_UNIT_MISALIGN_SPLIT_EN
  assign req_ok = legal_f3(bus.req_funct3);
  assign split  = (int'(off_q) + int'(size_q)) > NB;
`else
  assign req_ok = legal_f3(bus.req_funct3) &&
                  !(|({1'b0, bus.req_addr[2:0]} & (size_of(bus.req_funct3) - 4'd1)));
  assign split  = 1'b0;
`endif

  // Extraction works on the current beat, with beat0 below it when finishing a split load
  always_comb begin
    word = (state == BEAT1) ? {bus.mem_rdata, beat0_q} : {{XLEN{1'b0}}, bus.mem_rdata};
    sh   = XLEN'(word >> {off_q, 3'b000});
    case (size_q)
      4'd1:    ext = ~f3_q[2] & sh[7];
      4'd2:    ext = ~f3_q[2] & sh[15];
      4'd4:    ext = ~f3_q[2] & sh[31];
      default: ext = ~f3_q[2] & sh[XLEN-1];
    endcase
    res = '0;
    for (int i = 0; i < NB; i++)
      res[8*i +: 8] = (i < int'(size_q)) ? sh[8*i +: 8] : {8{ext}};
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (bus.req_valid)  state_nxt = req_ok ? BEAT0 : RESP;
      BEAT0: if (bus.mem_rvalid) state_nxt = split ? BEAT1 : RESP;
      BEAT1: if (bus.mem_rvalid) state_nxt = RESP;
      RESP:  if (bus.resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      f3_q        <= '0;
      addr_q      <= '0;
      beat0_q     <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.req_valid) begin
          f3_q        <= bus.req_funct3;
          addr_q      <= bus.req_addr;
          resp_data_q <= '0;
          resp_err_q  <= ~req_ok;
        end
        BEAT0: if (bus.mem_rvalid) begin
          beat0_q     <= bus.mem_rdata;
          resp_data_q <= res;
        end
        BEAT1: if (bus.mem_rvalid) resp_data_q <= res;
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.req_ready  = (state == IDLE);
    bus.mem_req    = (state == BEAT0) || (state == BEAT1);
    bus.mem_addr   = '0;
    if (state == BEAT0) bus.mem_addr = base_addr;
    if (state == BEAT1) bus.mem_addr = base_addr + AW'(NB);
    bus.resp_valid = (state == RESP);
    bus.resp_data  = resp_data_q;
    bus.resp_err   = resp_err_q;
  end
endmodule

// File: tb/tb_load_unit.sv
// tb/tb_load_unit.sv - directed self-checking bench for load_unit at XLEN=32
module tb_load_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  int   resp_cnt = 0;

  load_unit_if #(.XLEN(32), .AW(32)) bus ();

  load_unit #(.XLEN(32), .AW(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  always @(posedge clk) if (bus.resp_valid) resp_cnt <= resp_cnt + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input int beats, input logic [31:0] w0, input logic [31:0] w1,
                          input logic [31:0] a0, input int delay, input int hold,
                          input logic [31:0] exp_data, input logic exp_err);
    logic [31:0] a1;
    a1 = a0 + 32'd4;
    @(negedge clk);
    check({tag, ".req_ready"}, 64'(bus.req_ready), 64'd1);
    bus.req_valid  = 1'b1;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    for (int b = 0; b < beats; b++) begin
      for (int d = 0; d <= delay; d++) begin
        @(negedge clk);
        check({tag, ".mem_req"}, 64'(bus.mem_req), 64'd1);
        check({tag, ".mem_addr"}, 64'(bus.mem_addr), 64'(b == 0 ? a0 : a1));
        if (d == delay) begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata  = (b == 0) ? w0 : w1;
        end
        @(posedge clk); #1;
        bus.mem_rvalid = 1'b0;
      end
    end
    @(negedge clk);
    check({tag, ".mem_req_off"}, 64'(bus.mem_req), 64'd0);
    check({tag, ".resp_valid"}, 64'(bus.resp_valid), 64'd1);
    check({tag, ".resp_data"}, 64'(bus.resp_data), 64'(exp_data));
    check({tag, ".resp_err"}, 64'(bus.resp_err), 64'(exp_err));
    for (int h = 0; h < hold; h++) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'hA5A5A5A5;
      @(posedge clk); #1;
      bus.mem_rvalid = 1'b0;
      @(negedge clk);
      check({tag, ".hold_valid"}, 64'(bus.resp_valid), 64'd1);
      check({tag, ".hold_data"}, 64'(bus.resp_data), 64'(exp_data));
      check({tag, ".hold_ready"}, 64'(bus.req_ready), 64'd0);
    end
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    @(negedge clk);
    check({tag, ".idle"}, 64'(bus.req_ready), 64'd1);
    check({tag, ".resp_done"}, 64'(bus.resp_valid), 64'd0);
  endtask

  initial begin
    int cnt0;
    bus.req_valid  = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = '0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    bus.resp_ready = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.req_ready", 64'(bus.req_ready), 64'd1);
    check("rst.mem_req", 64'(bus.mem_req), 64'd0);
    check("rst.mem_addr", 64'(bus.mem_addr), 64'd0);
    check("rst.resp_valid", 64'(bus.resp_valid), 64'd0);
    check("rst.resp_data", 64'(bus.resp_data), 64'd0);
    check("rst.resp_err", 64'(bus.resp_err), 64'd0);
    rst = 1'b0;

    run_load("lb",     3'b000, 32'h1003, 1, 32'h80FF1234, 32'h0, 32'h1000, 0, 0, 32'hFFFFFF80, 1'b0);
    run_load("lhu",    3'b101, 32'h1002, 1, 32'hBEEF0000, 32'h0, 32'h1000, 0, 0, 32'h0000BEEF, 1'b0);
    run_load("lbu",    3'b100, 32'h2001, 1, 32'h1234F6AA, 32'h0, 32'h2000, 0, 0, 32'h000000F6, 1'b0);
    run_load("lb_neg", 3'b000, 32'h2001, 1, 32'h1234F6AA, 32'h0, 32'h2000, 0, 0, 32'hFFFFFFF6, 1'b0);
    run_load("lh",     3'b001, 32'h2000, 1, 32'h00018001, 32'h0, 32'h2000, 0, 0, 32'hFFFF8001, 1'b0);
    run_load("lw_wait",3'b010, 32'h3000, 1, 32'hDEADBEEF, 32'h0, 32'h3000, 2, 0, 32'hDEADBEEF, 1'b0);
    run_load("ld_ill", 3'b011, 32'h3000, 0, 32'h0, 32'h0, 32'h0, 0, 0, 32'h0, 1'b1);
    run_load("lwu_ill",3'b110, 32'h3000, 0, 32'h0, 32'h0, 32'h0, 0, 0, 32'h0, 1'b1);
    run_load("f3_111", 3'b111, 32'h3000, 0, 32'h0, 32'h0, 32'h0, 0, 0, 32'h0, 1'b1);
`ifdef LOAD_UNIT_MISALIGN_SPLIT_EN
    run_load("lw_split", 3'b010, 32'h1002, 2, 32'h55667788, 32'h11223344, 32'h1000, 0, 0, 32'h33445566, 1'b0);
    run_load("lh_mis",   3'b001, 32'h2001, 1, 32'hAABBCCDD, 32'h0, 32'h2000, 0, 0, 32'hFFFFBBCC, 1'b0);
    run_load("lhu_wrap", 3'b101, 32'hFFFFFFFF, 2, 32'h11000000, 32'h00000022, 32'hFFFFFFFC, 1, 0, 32'h00002211, 1'b0);
`else
    run_load("lw_split", 3'b010, 32'h1002, 0, 32'h0, 32'h0, 32'h0, 0, 0, 32'h0, 1'b1);
    run_load("lh_mis",   3'b001, 32'h2001, 0, 32'h0, 32'h0, 32'h0, 0, 0, 32'h0, 1'b1);
    run_load("lhu_wrap", 3'b101, 32'hFFFFFFFF, 0, 32'h0, 32'h0, 32'h0, 0, 0, 32'h0, 1'b1);
`endif
    run_load("bp", 3'b100, 32'h5000, 1, 32'h0000007F, 32'h0, 32'h5000, 0, 3, 32'h0000007F, 1'b0);

    // Reset while BEAT0 waits, then a late read return
    cnt0 = resp_cnt;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_funct3 = 3'b010; bus.req_addr = 32'h4000;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("abort.mem_req_before", 64'(bus.mem_req), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    check("abort.mem_req", 64'(bus.mem_req), 64'd0);
    check("abort.req_ready", 64'(bus.req_ready), 64'd1);
    @(posedge clk); #1;
    bus.mem_rvalid = 1'b0;
    repeat (3) @(negedge clk);
    check("abort.no_resp", 64'(resp_cnt - cnt0), 64'd0);
    check("abort.mem_req_late", 64'(bus.mem_req), 64'd0);

    // New request held during the response handshake must wait for the next IDLE cycle
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_funct3 = 3'b100; bus.req_addr = 32'h6000;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h00000011;
    @(posedge clk); #1;
    bus.mem_rvalid = 1'b0;
    @(negedge clk);
    check("overlap.resp_data", 64'(bus.resp_data), 64'h11);
    bus.resp_ready = 1'b1;
    bus.req_valid = 1'b1; bus.req_funct3 = 3'b010; bus.req_addr = 32'h6004;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    @(negedge clk);
    check("overlap.not_taken", 64'(bus.mem_req), 64'd0);
    check("overlap.idle", 64'(bus.req_ready), 64'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("overlap.taken", 64'(bus.mem_req), 64'd1);
    check("overlap.addr", 64'(bus.mem_addr), 64'h6004);
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h87654321;
    @(posedge clk); #1;
    bus.mem_rvalid = 1'b0;
    @(negedge clk);
    check("overlap.resp2", 64'(bus.resp_data), 64'h87654321);
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    @(negedge clk);
    check("overlap.end_idle", 64'(bus.req_ready), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/load_unit.md
LOAD_UNIT -- requirements
Module: load_unit

Interface
REQ-001 The block SHALL have a parameter XLEN, default 32, setting data width; legal values are 32 and 64.
REQ-002 The block SHALL have a parameter AW, default 32, setting byte-address width.
REQ-003 The block SHALL run on one clock with a synchronous, active-high reset: clk in 1 (rising-edge clock); rst in 1 (synchronous, active-high reset).
REQ-004 The block SHALL have the following request ports: req_valid in 1 (load request); req_ready out 1 (unit can accept); req_funct3 in 3 (instr[14:12] load type); req_addr in AW (byte address).
REQ-005 The block SHALL have the following memory ports: mem_req out 1 (read request); mem_addr out AW (XLEN/8-aligned address); mem_rvalid in 1 (read data valid); mem_rdata in XLEN (little-endian word).
REQ-006 The block SHALL have the following response ports: resp_valid out 1; resp_ready in 1; resp_data out XLEN (extended result); resp_err out 1 (illegal or misaligned request).

Function
REQ-007 The block SHALL decode funct3 as follows: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; 011 LD and 110 LWU are legal only when XLEN=64; every other code is illegal.
REQ-008 Access size SHALL be 1, 2, 4 or 8 bytes; offset = req_addr mod (XLEN/8).
REQ-009 The FSM SHALL have states IDLE, BEAT0, BEAT1 and RESP, with req_ready=1 only in IDLE.
REQ-010 A handshake (req_valid & req_ready) SHALL latch funct3/addr and move to BEAT0, or to RESP with resp_err=1 and resp_data=0 if the request is illegal, with no memory access.
REQ-011 In BEAT0 and BEAT1, mem_req SHALL be 1 and mem_addr/mem_req SHALL remain stable until mem_rvalid; exactly one read SHALL be outstanding.
REQ-012 BEAT0 mem_addr SHALL be the latched address with its low log2(XLEN/8) bits cleared; BEAT1 mem_addr SHALL be BEAT0 address + XLEN/8, wrapping modulo 2^AW.
REQ-013 On mem_rvalid in BEAT0, the block SHALL store the word and go to BEAT1 if offset+size > XLEN/8, else to RESP.
REQ-014 On mem_rvalid in BEAT1, the block SHALL store the second word and go to RESP.
REQ-015 Result SHALL be {beat1, beat0} shifted right by 8*offset, truncated to size bytes, then sign-extended (LB, LH, LW when XLEN=64) or zero-extended (LBU, LHU, LWU) to XLEN; LW at XLEN=32 and LD at XLEN=64 SHALL pass through unextended.
REQ-016 resp_valid, resp_data and resp_err SHALL be registered and held stable in RESP until resp_ready; the block SHALL return to IDLE in the cycle after resp_valid & resp_ready.
REQ-017 Latency: aligned load handshake at cycle N -> mem_req at N+1; mem_rvalid at M -> resp_valid at M+1; a split load adds one beat.
REQ-018 mem_rvalid SHALL be ignored in IDLE and RESP.
REQ-019 A new request SHALL NOT be accepted in the same cycle a response completes; it is accepted at the earliest in the following IDLE cycle.

Reset
REQ-020 While rst=1, the state SHALL be IDLE and outputs SHALL be: req_ready=1, mem_req=0, mem_addr=0, resp_valid=0, resp_data=0, resp_err=0.
REQ-021 Reset asserted mid-transaction SHALL abandon it: no response is produced, and a mem_rvalid arriving for the abandoned read SHALL be ignored.

Configuration
REQ-022 Macro LOAD_UNIT_MISALIGN_SPLIT_EN defined: misaligned loads SHALL be supported, including two-beat word-crossing loads per REQ-013 to REQ-015.
REQ-023 Macro LOAD_UNIT_MISALIGN_SPLIT_EN undefined: any address not a multiple of size SHALL be treated as illegal per REQ-010 (resp_err=1, no memory access); BEAT1 SHALL be unreachable.

Verification (XLEN=32)
REQ-024 LB addr 0x1003, mem_rdata 0x80FF1234 -> mem_addr 0x1000, resp_data 0xFFFFFF80, resp_err 0.
REQ-025 LHU addr 0x1002, mem_rdata 0xBEEF0000 -> resp_data 0x0000BEEF, one memory beat.
REQ-026 LW addr 0x1002, macro defined: beat0 0x1000 -> 0x55667788, beat1 0x1004 -> 0x11223344 -> resp_data 0x33445566; macro undefined -> resp_err 1, resp_data 0, mem_req never asserted.
REQ-027 funct3 011 -> resp_err 1, resp_data 0, no mem_req.
REQ-028 rst pulsed while in BEAT0 waiting, followed by a late mem_rvalid -> next cycle mem_req 0 and req_ready 1; no resp_valid ever.
REQ-029 resp_ready held low 3 cycles -> resp_valid/resp_data stable and req_ready 0 throughout; IDLE on the cycle after resp_ready=1.
